tpiu_formatter_tx: RTL and testbench

Synthesizable TPIU-style continuous-mode trace port transmitter: accepts a byte stream on a valid/ready handshake, packs it into 16-byte formatter frames under a single trace ID, and drives a 4-bit trace data port, inserting full-sync packets periodically and when idle. It is the transmit counterpart to the trace capture path fed by `TRACEDATA`/`TRCENA`. It serves as a synthesizable replacement for the simulation trace generator and as a loopback source for bring-up of the capture logic.

---
 rtl/tpiu_tx_pkg.sv | 22 ++
 rtl/tpiu_formatter_tx_if.sv | 22 ++
 rtl/trace_tx_fifo.sv | 49 ++++
 rtl/tpiu_formatter_tx.sv | 176 +++++++++++++++++
 tb/tb_tpiu_formatter_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tpiu_tx_pkg.sv
// Shared types and constants for the TPIU continuous-mode trace transmitter.
package tpiu_tx_pkg;

    typedef enum logic [1:0] {
        StOff,
        StSync,
        StFrame
    } tx_state_e;

    // Full-sync packet, byte 0 in the low byte: FF FF FF 7F.
    localparam logic [31:0] SYNC_BYTES   = 32'h7FFF_FFFF;
    localparam int unsigned SYNC_NIBBLES = 8;
    localparam int unsigned FRAME_BYTES  = 16;
    localparam int unsigned DATA_SLOTS   = 14;
    localparam logic [7:0]  NULL_ID_BYTE = 8'h01;

    // Even slots carry d[7:1] in the upper bits; d[0] travels in the aux byte.
    function automatic logic [7:0] even_slot_byte(input logic [7:0] d);
        return {d[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/tpiu_formatter_tx_if.sv
// Byte-stream input and trace-port output of the TPIU transmitter.
interface tpiu_formatter_tx_if;

    logic       I_enable;
    logic [7:0] I_data;
    logic       I_valid;
    logic       O_ready;
    logic [3:0] O_tracedata;
    logic       O_frame_start;
    logic       O_active;

    modport master (
        output I_enable, I_data, I_valid,
        input  O_ready, O_tracedata, O_frame_start, O_active
    );

    modport slave (
        input  I_enable, I_data, I_valid,
        output O_ready, O_tracedata, O_frame_start, O_active
    );

endinterface

// File: rtl/trace_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; pointers wrap modulo the depth.
module trace_tx_fifo #(
    parameter int unsigned pDEPTH = 32
) (
    input  logic                     trace_clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(pDEPTH):0]  count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [pDEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(pDEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge trace_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tpiu_formatter_tx.sv
// TPIU continuous-mode transmitter: packs a byte stream into 16-byte formatter frames
// on a 4-bit trace port, filling idle time and periodic gaps with full-sync packets.
module tpiu_formatter_tx
    import tpiu_tx_pkg::*;
#(
    parameter logic [6:0]  pTRACE_ID     = 7'h01,
    parameter int unsigned pFIFO_DEPTH   = 32,
    parameter int unsigned pFLUSH_CYCLES = 256,
    parameter int unsigned pSYNC_FRAMES  = 32
) (
    input  logic               trace_clk,
    input  logic               reset,
    tpiu_formatter_tx_if.slave tx
);

    localparam int unsigned CntW   = $clog2(pFIFO_DEPTH) + 1;
    localparam int unsigned FlushW = $clog2(pFLUSH_CYCLES + 1);
    localparam int unsigned FrameW = $clog2(pSYNC_FRAMES + 1);

    localparam logic [CntW-1:0]   FullCnt    = CntW'(DATA_SLOTS);
    localparam logic [FlushW-1:0] FlushLimit = FlushW'(pFLUSH_CYCLES);
    localparam logic [FrameW-1:0] SyncLimit  = FrameW'(pSYNC_FRAMES);
    localparam logic [4:0]        SyncLast   = 5'(SYNC_NIBBLES - 1);
    localparam logic [4:0]        FrameLast  = 5'(2 * FRAME_BYTES - 1);

    tx_state_e         state_q, state_d;
    logic [4:0]        nib_q;
    logic [3:0]        n_q;
    logic [FrameW-1:0] frame_cnt_q;
    logic [FlushW-1:0] flush_q;
    logic [7:0]        aux_q;
    logic [7:0]        byte_q;
    logic [3:0]        tracedata_q;
    logic              frame_start_q;

    logic [7:0]      fifo_rdata;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ready;
    logic            pop;

    logic [3:0] slot;
    logic       half;
    logic       last_nib;
    logic       frame_ready;
    logic       enter_frame;
    logic       sync_due;
    logic       pad_even;
    logic       data_here;
    logic [7:0] cur_byte;
    logic       aux_set;
    logic [3:0] nibble_d;
    logic       frame_start_d;

    assign ready = !fifo_full && !reset;

    trace_tx_fifo #(
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .trace_clk (trace_clk),
        .reset     (reset),
        .push_i    (tx.I_valid && ready),
        .wdata_i   (tx.I_data),
        .pop_i     (pop),
        .rdata_o   (fifo_rdata),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign slot        = nib_q[4:1];
    assign half        = nib_q[0];
    assign last_nib    = (state_q == StSync && nib_q == SyncLast) ||
                         (state_q == StFrame && nib_q == FrameLast);
    assign frame_ready = (fifo_count >= FullCnt) || (!fifo_empty && flush_q >= FlushLimit);
    assign enter_frame = last_nib && (state_d == StFrame);
    assign sync_due    = last_nib && (state_d == StSync) && (frame_cnt_q == SyncLimit);

    // An even-length short frame puts the null ID in slot n and shifts byte n to slot n+1.
    assign pad_even  = !n_q[0] && (n_q != 4'(DATA_SLOTS));
    assign data_here = (slot < n_q) || (slot == n_q && !pad_even) ||
                       (slot == n_q + 4'd1 && pad_even);

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) state_q <= StOff;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff: if (tx.I_enable) state_d = StSync;
            StSync, StFrame: begin
                if (last_nib) begin
                    if (!tx.I_enable)                 state_d = StOff;
                    else if (frame_cnt_q == SyncLimit) state_d = StSync;
                    else if (frame_ready)             state_d = StFrame;
                    else                              state_d = StSync;
                end
            end
            default: state_d = StOff;
        endcase
    end

    always_comb begin
        cur_byte = '0;
        pop      = 1'b0;
        aux_set  = 1'b0;
        unique case (state_q)
            StSync: cur_byte = SYNC_BYTES[{nib_q[2:1], 3'b000} +: 8];
            StFrame: begin
                if (half) begin
                    cur_byte = byte_q;
                end else if (slot == 4'd0) begin
                    cur_byte = {pTRACE_ID, 1'b1};
                end else if (slot == 4'd15) begin
                    cur_byte = aux_q;
                end else if (data_here) begin
                    pop = 1'b1;
                    if (slot[0]) begin
                        cur_byte = fifo_rdata;
                    end else begin
                        cur_byte = even_slot_byte(fifo_rdata);
                        aux_set  = fifo_rdata[0];
                    end
                end else if (slot == n_q) begin
                    cur_byte = NULL_ID_BYTE;
                    aux_set  = 1'b1;
                end else if (slot == n_q + 4'd1) begin
                    cur_byte = NULL_ID_BYTE;
                end
            end
            default: ;
        endcase
        nibble_d      = (state_q == StOff) ? 4'h0 : (half ? cur_byte[7:4] : cur_byte[3:0]);
        frame_start_d = (state_q == StFrame) && (nib_q == 5'd0);
    end

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            nib_q         <= '0;
            n_q           <= '0;
            frame_cnt_q   <= '0;
            flush_q       <= '0;
            aux_q         <= '0;
            byte_q        <= '0;
            tracedata_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            tracedata_q   <= nibble_d;
            frame_start_q <= frame_start_d;
            if (!half) byte_q <= cur_byte;
            if (state_q == StOff || last_nib) nib_q <= '0;
            else                              nib_q <= nib_q + 5'd1;
            if (enter_frame) begin
                n_q         <= (fifo_count >= FullCnt) ? 4'(DATA_SLOTS) : fifo_count[3:0];
                aux_q       <= '0;
                flush_q     <= '0;
                frame_cnt_q <= frame_cnt_q + FrameW'(1);
            end else begin
                if (aux_set) aux_q[slot[3:1]] <= 1'b1;
                if (state_q != StFrame && !fifo_empty && flush_q != FlushLimit) begin
                    flush_q <= flush_q + FlushW'(1);
                end
                if (sync_due) frame_cnt_q <= '0;
            end
        end
    end

    assign tx.O_ready       = ready;
    assign tx.O_tracedata   = tracedata_q;
    assign tx.O_frame_start = frame_start_q;
    assign tx.O_active      = (state_q != StOff);

endmodule

// File: tb/tb_tpiu_formatter_tx.sv
// Directed bench for tpiu_formatter_tx: frame vectors, sync insertion, back-pressure, reset.
module tb_tpiu_formatter_tx;

    typedef struct packed {
        logic [3:0]   n;
        logic [111:0] data;   // byte 1 in the top byte
        logic [127:0] exp;    // slot 0 in the top byte
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;

    logic trace_clk = 1'b0;
    logic reset;

    logic [3:0] st [1072];
    logic       fs [1072];

    tpiu_formatter_tx_if ifc ();

    tpiu_formatter_tx #(
        .pTRACE_ID     (7'h01),
        .pFIFO_DEPTH   (32),
        .pFLUSH_CYCLES (256),
        .pSYNC_FRAMES  (32)
    ) dut (
        .trace_clk (trace_clk),
        .reset     (reset),
        .tx        (ifc)
    );

    always #5 trace_clk = ~trace_clk;

    task automatic tick();
        @(posedge trace_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        ifc.I_valid = 1'b1;
        ifc.I_data  = d;
        tick();
        ifc.I_valid = 1'b0;
    endtask

    function automatic logic [127:0] sync_pattern(input int len);
        logic [127:0] p = '0;
        for (int i = 0; i < len; i++) p[4*i +: 4] = (i % 8 == 7) ? 4'h7 : 4'hF;
        return p;
    endfunction

    // Current sample must be the first nibble; ends on the last one.
    task automatic collect_nibbles(input int len, output logic [127:0] got, output int fs_cnt);
        got    = '0;
        fs_cnt = 0;
        for (int i = 0; i < len; i++) begin
            got[4*i +: 4] = ifc.O_tracedata;
            fs_cnt += int'(ifc.O_frame_start);
            if (i < len - 1) tick();
        end
    endtask

    task automatic get_frame(input string name, output logic [127:0] fr);
        int guard = 0;
        fr = '0;
        while (!ifc.O_frame_start && guard < 2000) begin
            tick();
            guard++;
        end
        if (!ifc.O_frame_start) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no frame_start, expected one within 2000 cycles", name);
        end else begin
            for (int i = 0; i < 32; i++) begin
                fr[127 - 8*(i/2) - ((i % 2 == 1) ? 0 : 4) -: 4] = ifc.O_tracedata;
                if (i < 31) tick();
            end
        end
    endtask

    task automatic quiet_check(input string name, input int cycles);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            cnt += int'(ifc.O_frame_start);
        end
        check(name, cnt, 0);
    endtask

    initial begin
        logic [127:0] fr;
        logic [127:0] got;
        int           fsc;
        int           mis;
        int           ctr;
        int           guard;
        logic         acc;
        logic         exp_fs;

        vecs[0] = '{n: 4'd14, data: {14{8'hFF}},
                    exp: {8'h03, {7{8'hFF, 8'hFE}}, 8'hFE}};
        vecs[1] = '{n: 4'd2, data: {8'h55, 8'hAA, 96'h0},
                    exp: {8'h03, 8'h55, 8'h01, 8'hAA, 88'h0, 8'h02}};
        vecs[2] = '{n: 4'd1, data: {8'h5A, 104'h0},
                    exp: {8'h03, 8'h5A, 8'h01, 96'h0, 8'h00}};
        vecs[3] = '{n: 4'd3, data: {8'h12, 8'h35, 8'h57, 88'h0},
                    exp: {8'h03, 8'h12, 8'h34, 8'h57, 8'h01, 80'h0, 8'h02}};
        vecs[4] = '{n: 4'd4, data: {8'h81, 8'h83, 8'hC0, 8'h7F, 80'h0},
                    exp: {8'h03, 8'h81, 8'h82, 8'hC0, 8'h01, 8'h7F, 72'h0, 8'h06}};
        vecs[5] = '{n: 4'd14,
                    data: {8'hC3, 8'h03, 8'h5A, 8'h10, 8'h00, 8'h21, 8'hFF,
                           8'h44, 8'h80, 8'h99, 8'h01, 8'hF0, 8'h7E, 8'h0F},
                    exp: {8'h03, 8'hC3, 8'h02, 8'h5A, 8'h10, 8'h00, 8'h20, 8'hFF,
                          8'h44, 8'h80, 8'h98, 8'h01, 8'hF0, 8'h7E, 8'h0E, 8'hAA}};

        // Reset state
        reset        = 1'b1;
        ifc.I_enable = 1'b0;
        ifc.I_valid  = 1'b0;
        ifc.I_data   = 8'h00;
        tick();
        tick();
        check("reset_tracedata", ifc.O_tracedata, 0);
        check("reset_frame_start", ifc.O_frame_start, 0);
        check("reset_active", ifc.O_active, 0);
        check("reset_ready", ifc.O_ready, 0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("ready_after_reset", ifc.O_ready, 1);
        check("off_idle", {ifc.O_active, ifc.O_tracedata}, 0);

        // Enable with empty FIFO: SYNC filler starts two edges after enable is driven
        ifc.I_enable = 1'b1;
        tick();
        check("sync_latency", ifc.O_tracedata, 0);
        check("active_on", ifc.O_active, 1);
        tick();
        collect_nibbles(24, got, fsc);
        check("idle_sync_stream", got, sync_pattern(24));
        check("idle_no_frame_start", fsc, 0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < int'(vecs[v].n); k++) push_byte(vecs[v].data[111 - 8*k -: 8]);
            get_frame($sformatf("vec%0d", v), fr);
            check($sformatf("vec%0d_frame", v), fr, vecs[v].exp);
            quiet_check($sformatf("vec%0d_fifo_empty", v), 300);
        end

        // Back-pressure with the port disabled; the 33rd byte must be dropped
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        ifc.I_enable = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        check("full_ready_low", ifc.O_ready, 0);
        push_byte(8'hEE);
        ifc.I_enable = 1'b1;
        get_frame("full_a", fr);
        check("full_frame_a", fr, {8'h03, 8'h00, 8'h00, 8'h02, 8'h02, 8'h04, 8'h04, 8'h06,
                                   8'h06, 8'h08, 8'h08, 8'h0A, 8'h0A, 8'h0C, 8'h0C, 8'hFE});
        tick();
        get_frame("full_b", fr);
        check("full_frame_b", fr, {8'h03, 8'h0E, 8'h0E, 8'h10, 8'h10, 8'h12, 8'h12, 8'h14,
                                   8'h14, 8'h16, 8'h16, 8'h18, 8'h18, 8'h1A, 8'h1A, 8'hFE});
        tick();
        get_frame("full_c", fr);
        check("full_frame_c", fr, {8'h03, 8'h1C, 8'h1C, 8'h1E, 8'h01, 8'h1F, 72'h0, 8'h06});

        // Continuous streaming over 33 frames: SYNC must follow frame 32 with no gap
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        ifc.I_enable = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        ctr          = 20;
        ifc.I_valid  = 1'b1;
        ifc.I_data   = 8'(ctr);
        ifc.I_enable = 1'b1;
        acc          = ifc.O_ready;
        tick();
        if (acc) ctr++;
        ifc.I_data = 8'(ctr);
        for (int i = 0; i < 1072; i++) begin
            acc = ifc.O_ready;
            tick();
            if (acc) ctr++;
            ifc.I_data = 8'(ctr);
            st[i] = ifc.O_tracedata;
            fs[i] = ifc.O_frame_start;
        end
        ifc.I_valid = 1'b0;
        mis = 0;
        for (int i = 0; i < 1072; i++) begin
            exp_fs = (i >= 8 && i < 1032 && (i - 8) % 32 == 0) || (i == 1040);
            if (fs[i] !== exp_fs) mis++;
        end
        check("stream_frame_start_positions", mis, 0);
        got = '0;
        for (int i = 0; i < 8; i++) got[4*i +: 4] = st[i];
        check("stream_first_sync", got, sync_pattern(8));
        got = '0;
        for (int i = 0; i < 8; i++) got[4*i +: 4] = st[1032 + i];
        check("stream_sync_after_32", got, sync_pattern(8));
        check("stream_frame33_id", {st[1041], st[1040]}, 8'h03);
        fr = '0;
        for (int s = 0; s < 16; s++) fr[127 - 8*s -: 8] = {st[8 + 2*s + 1], st[8 + 2*s]};
        check("stream_frame1", fr, {8'h03, 8'h00, 8'h00, 8'h02, 8'h02, 8'h04, 8'h04, 8'h06,
                                    8'h06, 8'h08, 8'h08, 8'h0A, 8'h0A, 8'h0C, 8'h0C, 8'hFE});

        // Reset in the middle of a frame
        guard = 0;
        while (!ifc.O_frame_start && guard < 200) begin
            tick();
            guard++;
        end
        check("midframe_found", ifc.O_frame_start, 1);
        for (int i = 0; i < 5; i++) tick();
        check("active_before_reset", ifc.O_active, 1);
        reset = 1'b1;
        #1;
        check("midframe_reset_outputs",
              {ifc.O_tracedata, ifc.O_active, ifc.O_frame_start, ifc.O_ready}, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        collect_nibbles(16, got, fsc);
        check("sync_after_reset", got, sync_pattern(16));
        check("no_frame_after_reset", fsc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
